serial_lut_loader: RTL

- Host-side transmitter for the team's serial-load LUT receiver (serial_load_lut: shift register clocked on its clk rising edge, enabled by cs_n low, MSB of table ends up first-shifted).
- Accepts a full parallel table word on a start handshake and serialises it MSB-first as a sd/sclk/cs_n stream, generating the receiver's sclk from the system clock.
- Lets on-chip logic or a test harness program any LUT instance without an external microcontroller.

---
 rtl/serial_lut_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/serial_lut_loader.sv
`default_nettype none
// ============================================================================
// Module   : serial_lut_loader
// Purpose  : Serialises a parallel LUT table MSB-first onto sd/sclk/cs_n for
//            the serial-load LUT receiver; sclk is derived from clk.
// Revision : 1.0 - initial release
// ============================================================================
module serial_lut_loader #(
  parameter int TABLE_BITS = 48,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TABLE_BITS-1:0] table_in,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  sd,
  output logic                  cs_n
);

  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(TABLE_BITS + 1);

  localparam logic [PH_W-1:0]  C_PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  C_PH_ONE   = PH_W'(1);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(TABLE_BITS - 1);
  localparam logic [BIT_W-1:0] C_BIT_FULL = BIT_W'(TABLE_BITS);
  localparam logic [BIT_W-1:0] C_BIT_ONE  = BIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [BIT_W-1:0]      bit_q,   bit_d;
  // Holds only the bits still to be sent; the bit on sd lives in sd_q.
  logic [TABLE_BITS-2:0] shreg_q, shreg_d;
  logic                  sclk_q,  sclk_d;
  logic                  sd_q,    sd_d;
  logic                  cs_n_q,  cs_n_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      sd_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      sd_q    <= sd_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    sd_d    = sd_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          shreg_d = table_in[TABLE_BITS-2:0];
          sd_d    = table_in[TABLE_BITS-1];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          phase_d = '0;
          bit_d   = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (phase_q == C_PH_LAST) begin
          phase_d = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end else begin
          phase_d = phase_q + C_PH_ONE;
        end
      end

      S_HIGH: begin
        if (phase_q == C_PH_LAST) begin
          phase_d = '0;
          bit_d   = bit_q + C_BIT_ONE;
          sclk_d  = 1'b0;
          state_d = S_LOW;
          // The final bit is left on sd through the closing LOW phase.
          if (bit_q != C_BIT_LAST) begin
            sd_d    = shreg_q[TABLE_BITS-2];
            shreg_d = shreg_q << 1;
          end
        end else begin
          phase_d = phase_q + C_PH_ONE;
        end
      end

      S_LOW: begin
        if (phase_q == C_PH_LAST) begin
          phase_d = '0;
          if (bit_q < C_BIT_FULL) begin
            sclk_d  = 1'b1;
            state_d = S_HIGH;
          end else begin
            state_d = S_IDLE;
            bit_d   = '0;
            shreg_d = '0;
            cs_n_d  = 1'b1;
            sd_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q + C_PH_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort dropping cs_n together with sclk is harmless: the receiver only
    // acts on sclk rising edges.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      phase_d = '0;
      bit_d   = '0;
      shreg_d = '0;
      sclk_d  = 1'b0;
      sd_d    = 1'b0;
      cs_n_d  = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sclk = sclk_q;
  assign sd   = sd_q;
  assign cs_n = cs_n_q;

endmodule
`default_nettype wire
